bypass_scoreboard_unit: RTL and testbench

BYPASS_SCOREBOARD_UNIT -- requirements
Module: bypass_scoreboard_unit

---
 rtl/bypass_scoreboard_unit.sv | 172 +++++++++++++++++
 tb/tb_bypass_scoreboard_unit.sv | 288 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/bypass_scoreboard_unit.sv
// Operand bypass select and hazard stall for the ID stage, plus an in-order MDU scoreboard.
// Optional macro BYPASS_PERF_CNT_EN adds the saturating Stall_Cycles counter output.
module bypass_scoreboard_unit #(
  parameter int unsigned NUM_SRC    = 2,
  parameter int unsigned FWD_STAGES = 2,
  parameter int unsigned MDU_LAT    = 4,
  parameter int unsigned MDU_SLOTS  = 2,
  localparam int unsigned SELW      = $clog2(FWD_STAGES + 2)
) (
  input  logic                      CLK,
  input  logic                      RST_N,
  input  logic [5*NUM_SRC-1:0]      ID_SrcAdr,
  input  logic [NUM_SRC-1:0]        ID_SrcUse,
  input  logic                      ID_RegWrite,
  input  logic [4:0]                ID_WAdr,
  input  logic                      ID_MduIssue,
  input  logic                      BranchCLR,
  input  logic [FWD_STAGES-1:0]     Stg_RegWrite,
  input  logic [5*FWD_STAGES-1:0]   Stg_WAdr,
  input  logic [FWD_STAGES-1:0]     Stg_Pending,
  output logic [SELW*NUM_SRC-1:0]   Src_Fwd,
  output logic                      Stall,
  output logic                      Mdu_WbValid,
  output logic [4:0]                Mdu_WbAdr
`ifdef BYPASS_PERF_CNT_EN
  ,
  output logic [31:0]               Stall_Cycles
`endif
);

  localparam int unsigned CNTW = 4;
  localparam logic [SELW-1:0] SEL_MDU = SELW'(FWD_STAGES + 1);

  logic [MDU_SLOTS-1:0]           valid_q, valid_d;
  logic [MDU_SLOTS-1:0][4:0]      dst_q, dst_d;
  logic [MDU_SLOTS-1:0][CNTW-1:0] cnt_q, cnt_d;

  logic [MDU_SLOTS-1:0]           retire_vec;
  logic [MDU_SLOTS-1:0]           busy_vec;
  logic                           wb_valid;
  logic [4:0]                     wb_adr;
  logic [SELW*NUM_SRC-1:0]        fwd_c;
  logic                           src_stall_c;
  logic                           waw_stall_c;
  logic                           full_stall_c;
  logic                           stall_c;
  logic                           issue_ok;

  // Retiring slot (at most one, fixed latency in order) and still-busy slots
  always_comb begin
    retire_vec = '0;
    busy_vec   = '0;
    wb_adr     = '0;
    for (int unsigned i = 0; i < MDU_SLOTS; i++) begin
      retire_vec[i] = valid_q[i] && (cnt_q[i] == CNTW'(1));
      busy_vec[i]   = valid_q[i] && !retire_vec[i];
      if (retire_vec[i]) wb_adr = wb_adr | dst_q[i];
    end
    wb_valid = |retire_vec;
  end

  // Per-source select: retiring MDU result, then youngest writing stage, then regfile
  always_comb begin : p_resolve
    logic [4:0] adr;
    logic       stg_found;
    logic       stg_pend;
    fwd_c       = '0;
    src_stall_c = 1'b0;
    adr         = '0;
    stg_found   = 1'b0;
    stg_pend    = 1'b0;
    for (int unsigned s = 0; s < NUM_SRC; s++) begin
      adr       = ID_SrcAdr[5*s +: 5];
      stg_found = 1'b0;
      stg_pend  = 1'b0;
      if (ID_SrcUse[s] && (adr != 5'd0)) begin
        for (int unsigned k = 0; k < FWD_STAGES; k++) begin
          if (!stg_found && Stg_RegWrite[k] && (Stg_WAdr[5*k +: 5] == adr)) begin
            stg_found                  = 1'b1;
            stg_pend                   = Stg_Pending[k];
            fwd_c[SELW*s +: SELW]      = SELW'(k + 1);
          end
        end
        if (wb_valid && (wb_adr == adr)) begin
          fwd_c[SELW*s +: SELW] = SEL_MDU;
        end else if (stg_pend) begin
          src_stall_c = 1'b1;
        end
        for (int unsigned i = 0; i < MDU_SLOTS; i++) begin
          if (busy_vec[i] && (dst_q[i] == adr)) src_stall_c = 1'b1;
        end
      end
    end
  end

  // Destination conflict with an in-flight MDU op, and slot exhaustion
  always_comb begin
    waw_stall_c = 1'b0;
    if (ID_RegWrite && (ID_WAdr != 5'd0)) begin
      for (int unsigned i = 0; i < MDU_SLOTS; i++) begin
        if (busy_vec[i] && (dst_q[i] == ID_WAdr)) waw_stall_c = 1'b1;
      end
    end
    full_stall_c = ID_MduIssue && (&valid_q);
    stall_c      = (src_stall_c || waw_stall_c || full_stall_c) && !BranchCLR;
    issue_ok     = ID_MduIssue && !stall_c && !BranchCLR;
  end

  assign Stall       = RST_N && stall_c;
  assign Src_Fwd     = RST_N ? fwd_c : '0;
  assign Mdu_WbValid = wb_valid;
  assign Mdu_WbAdr   = wb_adr;

  // Slot countdown, retire and issue into the lowest free slot
  always_comb begin : p_slot_next
    logic placed;
    valid_d = valid_q;
    dst_d   = dst_q;
    cnt_d   = cnt_q;
    placed  = 1'b0;
    for (int unsigned i = 0; i < MDU_SLOTS; i++) begin
      if (valid_q[i]) begin
        if (retire_vec[i]) begin
          valid_d[i] = 1'b0;
          cnt_d[i]   = '0;
        end else begin
          cnt_d[i] = cnt_q[i] - CNTW'(1);
        end
      end
    end
    if (issue_ok) begin
      for (int unsigned i = 0; i < MDU_SLOTS; i++) begin
        if (!placed && !valid_q[i]) begin
          placed     = 1'b1;
          valid_d[i] = 1'b1;
          dst_d[i]   = ID_WAdr;
          cnt_d[i]   = CNTW'(MDU_LAT);
        end
      end
    end
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      valid_q <= '0;
      dst_q   <= '0;
      cnt_q   <= '0;
    end else begin
      valid_q <= valid_d;
      dst_q   <= dst_d;
      cnt_q   <= cnt_d;
    end
  end

`ifdef BYPASS_PERF_CNT_EN
  logic [31:0] stall_cycles_q, stall_cycles_d;

  // Saturating count of stalled cycles
  always_comb begin
    stall_cycles_d = stall_cycles_q;
    if (Stall && (stall_cycles_q != 32'hFFFF_FFFF)) stall_cycles_d = stall_cycles_q + 32'd1;
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) stall_cycles_q <= '0;
    else        stall_cycles_q <= stall_cycles_d;
  end

  assign Stall_Cycles = stall_cycles_q;
`endif

endmodule

// File: tb/tb_bypass_scoreboard_unit.sv
// Directed bench for bypass_scoreboard_unit with default parameters (NUM_SRC=2, FWD_STAGES=2, MDU_LAT=4, MDU_SLOTS=2).
module tb_bypass_scoreboard_unit;

  logic        clk;
  logic        rst_n;
  logic [9:0]  id_src_adr;
  logic [1:0]  id_src_use;
  logic        id_reg_write;
  logic [4:0]  id_wadr;
  logic        id_mdu_issue;
  logic        branch_clr;
  logic [1:0]  stg_reg_write;
  logic [9:0]  stg_wadr;
  logic [1:0]  stg_pending;
  logic [3:0]  src_fwd;
  logic        stall;
  logic        mdu_wb_valid;
  logic [4:0]  mdu_wb_adr;
`ifdef BYPASS_PERF_CNT_EN
  logic [31:0] stall_cycles;
`endif

  int checks = 0;
  int errors = 0;

  bypass_scoreboard_unit dut (
    .CLK          (clk),
    .RST_N        (rst_n),
    .ID_SrcAdr    (id_src_adr),
    .ID_SrcUse    (id_src_use),
    .ID_RegWrite  (id_reg_write),
    .ID_WAdr      (id_wadr),
    .ID_MduIssue  (id_mdu_issue),
    .BranchCLR    (branch_clr),
    .Stg_RegWrite (stg_reg_write),
    .Stg_WAdr     (stg_wadr),
    .Stg_Pending  (stg_pending),
    .Src_Fwd      (src_fwd),
    .Stall        (stall),
    .Mdu_WbValid  (mdu_wb_valid),
    .Mdu_WbAdr    (mdu_wb_adr)
`ifdef BYPASS_PERF_CNT_EN
    ,
    .Stall_Cycles (stall_cycles)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic idle();
    id_src_adr    = '0;
    id_src_use    = '0;
    id_reg_write  = 1'b0;
    id_wadr       = '0;
    id_mdu_issue  = 1'b0;
    branch_clr    = 1'b0;
    stg_reg_write = '0;
    stg_wadr      = '0;
    stg_pending   = '0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n         = 1'b0;
    idle();
    stg_reg_write = 2'b11;
    stg_wadr      = {5'd6, 5'd7};
    stg_pending   = 2'b01;
    id_src_adr    = {5'd6, 5'd7};
    id_src_use    = 2'b11;
    #1;
    checks++; if (stall !== 1'b0) begin errors++; $display("FAIL reset_stall: got %0b expected 0", stall); end
    checks++; if (src_fwd !== 4'h0) begin errors++; $display("FAIL reset_fwd: got %0h expected 0", src_fwd); end
    checks++; if (mdu_wb_valid !== 1'b0) begin errors++; $display("FAIL reset_wbvalid: got %0b expected 0", mdu_wb_valid); end
    checks++; if (mdu_wb_adr !== 5'd0) begin errors++; $display("FAIL reset_wbadr: got %0d expected 0", mdu_wb_adr); end
    tick();
    rst_n = 1'b1;
    idle();
    tick();
  endtask

  task automatic test_forward();
    logic [1:0] rw [6]  = '{2'b01, 2'b11, 2'b10, 2'b11, 2'b01, 2'b11};
    logic [9:0] wa [6]  = '{{5'd0,5'd5}, {5'd5,5'd5}, {5'd6,5'd0}, {5'd6,5'd5}, {5'd5,5'd6}, {5'd5,5'd6}};
    logic [9:0] sa [6]  = '{{5'd0,5'd5}, {5'd5,5'd5}, {5'd6,5'd6}, {5'd5,5'd6}, {5'd5,5'd6}, {5'd6,5'd5}};
    logic [1:0] us [6]  = '{2'b01, 2'b11, 2'b10, 2'b00, 2'b11, 2'b11};
    logic [3:0] ef [6]  = '{4'b0001, 4'b0101, 4'b1000, 4'b0000, 4'b0001, 4'b0110};
    for (int v = 0; v < 6; v++) begin
      idle();
      stg_reg_write = rw[v];
      stg_wadr      = wa[v];
      id_src_adr    = sa[v];
      id_src_use    = us[v];
      #1;
      checks++; if (src_fwd !== ef[v]) begin errors++; $display("FAIL fwd_sel[%0d]: got %b expected %b", v, src_fwd, ef[v]); end
      checks++; if (stall !== 1'b0) begin errors++; $display("FAIL fwd_stall[%0d]: got %0b expected 0", v, stall); end
    end
    idle();
    tick();
  endtask

  task automatic test_load_use();
    logic [1:0] rw [7]  = '{2'b01, 2'b01, 2'b11, 2'b11, 2'b10, 2'b01, 2'b11};
    logic [9:0] wa [7]  = '{{5'd0,5'd7}, {5'd0,5'd7}, {5'd7,5'd7}, {5'd7,5'd7}, {5'd7,5'd0}, {5'd0,5'd7}, {5'd0,5'd0}};
    logic [1:0] pd [7]  = '{2'b01, 2'b01, 2'b10, 2'b01, 2'b10, 2'b01, 2'b11};
    logic [9:0] sa [7]  = '{{5'd0,5'd7}, {5'd0,5'd7}, {5'd0,5'd7}, {5'd0,5'd7}, {5'd7,5'd0}, {5'd0,5'd7}, {5'd0,5'd0}};
    logic [1:0] us [7]  = '{2'b01, 2'b01, 2'b01, 2'b01, 2'b10, 2'b00, 2'b11};
    logic       bc [7]  = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    logic       es [7]  = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
    logic       cf [7]  = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
    logic [3:0] ef [7]  = '{4'b0000, 4'b0000, 4'b0001, 4'b0000, 4'b0000, 4'b0000, 4'b0000};
    for (int v = 0; v < 7; v++) begin
      idle();
      stg_reg_write = rw[v];
      stg_wadr      = wa[v];
      stg_pending   = pd[v];
      id_src_adr    = sa[v];
      id_src_use    = us[v];
      branch_clr    = bc[v];
      #1;
      checks++; if (stall !== es[v]) begin errors++; $display("FAIL lu_stall[%0d]: got %0b expected %0b", v, stall, es[v]); end
      if (cf[v]) begin
        checks++; if (src_fwd !== ef[v]) begin errors++; $display("FAIL lu_fwd[%0d]: got %b expected %b", v, src_fwd, ef[v]); end
      end
    end
    idle();
    tick();
  endtask

  task automatic test_mdu_latency();
    idle();
    id_mdu_issue = 1'b1;
    id_reg_write = 1'b1;
    id_wadr      = 5'd9;
    #1;
    checks++; if (stall !== 1'b0) begin errors++; $display("FAIL lat_issue_stall: got %0b expected 0", stall); end
    tick();
    idle();
    id_src_adr = {5'd0, 5'd9};
    id_src_use = 2'b01;
    for (int c = 1; c <= 4; c++) begin
      #1;
      checks++; if (stall !== (c < 4)) begin errors++; $display("FAIL lat_stall[c%0d]: got %0b expected %0b", c, stall, (c < 4)); end
      checks++; if (mdu_wb_valid !== (c == 4)) begin errors++; $display("FAIL lat_wbvalid[c%0d]: got %0b expected %0b", c, mdu_wb_valid, (c == 4)); end
      if (c == 4) begin
        checks++; if (mdu_wb_adr !== 5'd9) begin errors++; $display("FAIL lat_wbadr: got %0d expected 9", mdu_wb_adr); end
        checks++; if (src_fwd[1:0] !== 2'd3) begin errors++; $display("FAIL lat_fwd_mdu: got %0d expected 3", src_fwd[1:0]); end
      end
      tick();
    end
    #1;
    checks++; if (mdu_wb_valid !== 1'b0) begin errors++; $display("FAIL lat_after_wb: got %0b expected 0", mdu_wb_valid); end
    checks++; if (src_fwd !== 4'h0) begin errors++; $display("FAIL lat_after_fwd: got %b expected 0000", src_fwd); end
    idle();
    tick();
  endtask

  task automatic test_full();
    logic       es [2:5] = '{1'b1, 1'b1, 1'b1, 1'b0};
    logic       ew [2:5] = '{1'b0, 1'b0, 1'b1, 1'b1};
    logic [4:0] ea [2:5] = '{5'd0, 5'd0, 5'd2, 5'd3};
    idle();
    id_mdu_issue = 1'b1;
    id_reg_write = 1'b1;
    id_wadr      = 5'd2;
    #1;
    checks++; if (stall !== 1'b0) begin errors++; $display("FAIL full_issue1_stall: got %0b expected 0", stall); end
    tick();
    id_wadr = 5'd3;
    #1;
    checks++; if (stall !== 1'b0) begin errors++; $display("FAIL full_issue2_stall: got %0b expected 0", stall); end
    tick();
    id_wadr = 5'd10;
    for (int c = 2; c <= 5; c++) begin
      #1;
      checks++; if (stall !== es[c]) begin errors++; $display("FAIL full_stall[c%0d]: got %0b expected %0b", c, stall, es[c]); end
      checks++; if (mdu_wb_valid !== ew[c]) begin errors++; $display("FAIL full_wbvalid[c%0d]: got %0b expected %0b", c, mdu_wb_valid, ew[c]); end
      if (ew[c]) begin
        checks++; if (mdu_wb_adr !== ea[c]) begin errors++; $display("FAIL full_wbadr[c%0d]: got %0d expected %0d", c, mdu_wb_adr, ea[c]); end
      end
      tick();
    end
    idle();
    for (int c = 6; c <= 9; c++) begin
      #1;
      checks++; if (mdu_wb_valid !== (c == 9)) begin errors++; $display("FAIL full_third_wb[c%0d]: got %0b expected %0b", c, mdu_wb_valid, (c == 9)); end
      if (c == 9) begin
        checks++; if (mdu_wb_adr !== 5'd10) begin errors++; $display("FAIL full_third_adr: got %0d expected 10", mdu_wb_adr); end
      end
      tick();
    end
  endtask

  task automatic test_waw();
    idle();
    id_mdu_issue = 1'b1;
    id_reg_write = 1'b1;
    id_wadr      = 5'd4;
    #1;
    checks++; if (stall !== 1'b0) begin errors++; $display("FAIL waw_issue_stall: got %0b expected 0", stall); end
    tick();
    idle();
    id_reg_write  = 1'b1;
    id_wadr       = 5'd4;
    stg_reg_write = 2'b01;
    stg_wadr      = {5'd0, 5'd4};
    for (int c = 1; c <= 4; c++) begin
      #1;
      checks++; if (stall !== (c < 4)) begin errors++; $display("FAIL waw_stall[c%0d]: got %0b expected %0b", c, stall, (c < 4)); end
      if (c == 4) begin
        checks++; if (mdu_wb_valid !== 1'b1 || mdu_wb_adr !== 5'd4) begin errors++; $display("FAIL waw_wb: got %0b/%0d expected 1/4", mdu_wb_valid, mdu_wb_adr); end
        id_src_adr = {5'd0, 5'd4};
        id_src_use = 2'b01;
        #1;
        checks++; if (src_fwd[1:0] !== 2'd3) begin errors++; $display("FAIL waw_mdu_over_stage: got %0d expected 3", src_fwd[1:0]); end
      end
      tick();
    end
    idle();
    tick();
  endtask

  task automatic test_reset_inflight();
    int wb_seen;
    wb_seen = 0;
    idle();
    id_mdu_issue = 1'b1;
    id_reg_write = 1'b1;
    id_wadr      = 5'd2;
    tick();
    id_wadr      = 5'd3;
    tick();
    idle();
    tick();
    rst_n = 1'b0;
    #1;
    checks++; if (mdu_wb_valid !== 1'b0) begin errors++; $display("FAIL rst_mid_wbvalid: got %0b expected 0", mdu_wb_valid); end
    tick();
    rst_n = 1'b1;
`ifdef BYPASS_PERF_CNT_EN
    checks++; if (stall_cycles !== 32'd0) begin errors++; $display("FAIL rst_stall_cycles: got %0d expected 0", stall_cycles); end
`endif
    for (int c = 0; c < 8; c++) begin
      #1;
      if (mdu_wb_valid === 1'b1) wb_seen++;
      tick();
    end
    checks++; if (wb_seen !== 0) begin errors++; $display("FAIL rst_inflight_wb: got %0d writebacks expected 0", wb_seen); end
`ifdef BYPASS_PERF_CNT_EN
    stg_reg_write = 2'b01;
    stg_wadr      = {5'd0, 5'd7};
    stg_pending   = 2'b01;
    id_src_adr    = {5'd0, 5'd7};
    id_src_use    = 2'b01;
    tick();
    tick();
    idle();
    #1;
    checks++; if (stall_cycles !== 32'd2) begin errors++; $display("FAIL stall_cycles_count: got %0d expected 2", stall_cycles); end
`endif
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0;
    idle();
    test_reset();
    test_forward();
    test_load_use();
    test_mdu_latency();
    test_full();
    test_waw();
    test_reset_inflight();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
